regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
Debug-side reader for the CPU register file. On a start request it walks a register address range through one regfile read port and captures each 32-bit value. It serialises each value onto an 8-bit valid/ready byte stream for a UART or display drain, and sits beside the regfile on the debug path. It never writes the regfile.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width; fixed at 32 (4 bytes per register)

Ports:
clk  in  1  clock, rising edge active
rst  in  1  reset, synchronous, active-low; rst=0 at a rising clk edge resets the block
start  in  1  dump request, sampled only in IDLE
first_addr  in  ADDR_W  first register to dump, latched on accepted start
last_addr  in  ADDR_W  last register to dump, inclusive, latched on accepted start
raddr  out  ADDR_W  regfile read address
rdata  in  DATA_W  regfile read data; combinational, valid in the same cycle as raddr
tx_data  out  8  stream byte
tx_valid  out  1  stream byte valid
tx_ready  in  1  sink accepts the byte when tx_valid & tx_ready at a clk edge
busy  out  1  high from the accepted start until the done cycle, exclusive
done  out  1  one-cycle pulse at the end of a dump, including an empty dump

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; raddr=0, tx_data=0, tx_valid=0, busy=0, done=0; internal cur, last, byte_cnt and shift register cleared. Reset applies from any state: an in-flight byte is dropped and no done pulse is issued.
- States: IDLE, FETCH, SEND, FIN.
- IDLE, start=1, first_addr<=last_addr:
  - latch cur=first_addr and last=last_addr; raddr=first_addr; busy=1
  - next state FETCH
- IDLE, start=1, first_addr>last_addr (empty range): next state FIN. No bytes are emitted and busy stays 0.
- IDLE, start=0: no change. start while busy is ignored; it is not queued.
- FETCH (exactly 1 cycle):
  - raddr=cur; capture rdata into a 32-bit shift register; byte_cnt=0
  - next state SEND
  - The captured value is a snapshot. Regfile writes to cur after this edge are not reflected in the dump.
- SEND: tx_valid=1. Per register, five bytes go out in this order:
  - byte 0 is the header {3'b000, cur}
  - bytes 1..4 are data[7:0], [15:8], [23:16], [31:24] (LSB first)
- Stream rules:
  - tx_data and tx_valid are registered outputs.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable.
  - tx_valid never drops without a transfer, except on reset.
- On each transfer, byte_cnt increments. On the transfer of byte 4:
  - if cur==last, go to FIN with tx_valid=0
  - otherwise cur=cur+1, raddr=cur+1, go to FETCH
- cur never wraps past 31: with last<=31 and cur<=last, the last==cur compare ends the dump first.
- FIN (1 cycle): done=1, busy=0, then IDLE. A start in the FIN cycle is ignored.
- Timing:
  - start accepted at edge N; FETCH in cycle N+1; first header byte valid in cycle N+2
  - with tx_ready held at 1: 5 bytes per register on consecutive cycles, plus 1 FETCH bubble between registers
  - done is asserted the cycle after the final byte transfer
- Total bytes per dump = 5*(last_addr-first_addr+1).
- raddr holds its last value in IDLE.

Decomposition:
- Shared package:
  - state enum {IDLE, FETCH, SEND, FIN}
  - BYTES_PER_REG=5
  - header tag width constant (3 zero bits)
- One natural sub-module: regfile_dump_ser. It takes a word plus address on load and emits the 5-byte valid/ready sequence, with a last-byte pulse. The top-level FSM owns the address walk.

Test Plan:
1. Hold rst=0 for 2 edges, then release. Required: raddr=0, tx_valid=0, busy=0, done=0; no activity with start=0.
2. Regfile r3=0x12345678; start with first=3, last=3; tx_ready=1. Required: bytes 0x03, 0x78, 0x56, 0x34, 0x12 on 5 consecutive cycles from start+2; done pulses the cycle after 0x12; busy falls with done.
3. r0=0, r1=0xA5A5_0F0F; range 0..1; tx_ready toggles 1,0,1,0. Required: 10 bytes 00,00,00,00,00,01,0F,0F,A5,A5; tx_data stable in every stalled cycle.
4. start with first=5, last=2. Required: tx_valid never asserts; busy stays 0; done pulses exactly once, at start+1.
5. Drive rst=0 mid-SEND, during the third byte of r7. Required: next edge gives tx_valid=0, busy=0, no done. A fresh start for 7..7 then emits all 5 bytes correctly.
6. Range 4..4: write r4=0xFFFF_FFFF after FETCH; pulse start again during SEND. Required: the old value is sent, the second start is ignored, and done pulses once.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and constants for the register-file dump reader.
package regfile_dump_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } state_e;

  // One header byte followed by four data bytes per register.
  localparam int BYTES_PER_REG = 5;
  // Zero bits placed above the register address in the header byte.
  localparam int HDR_TAG_W     = 3;
  localparam int BYTE_CNT_W    = 3;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Regfile read port plus the outgoing valid/ready byte stream.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // Dump reader side.
  modport master (output raddr, tx_data, tx_valid, input rdata, tx_ready);
  // Regfile and byte sink side.
  modport slave  (input raddr, tx_data, tx_valid, output rdata, tx_ready);
endinterface

// File: rtl/regfile_dump_reader_ser.sv
// Serialises one register snapshot into header + 4 data bytes (LSB first).
module regfile_dump_reader_ser
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,       // synchronous, active-low
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              tx_ready_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  output logic              last_o
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_REG - 1);

  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  xfer;

  // Load presents the header; each accepted byte advances to the next data byte.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    last_o     = 1'b0;
    xfer       = tx_valid_q & tx_ready_i;
    if (load_i) begin
      shift_d    = word_i;
      byte_cnt_d = '0;
      tx_data_d  = {{HDR_TAG_W{1'b0}}, addr_i};
      tx_valid_d = 1'b1;
    end else if (xfer) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      if (byte_cnt_q == LAST_BYTE) begin
        tx_valid_d = 1'b0;
        last_o     = 1'b1;
      end else begin
        tx_data_d = shift_q[7:0];
        shift_d   = shift_q >> 8;
      end
    end
  end

  // Registered stream outputs and shift state.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register range through one read port and streams each value out.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,        // synchronous, active-low
  input  logic                        start,
  input  logic [ADDR_W-1:0]           first_addr,
  input  logic [ADDR_W-1:0]           last_addr,
  output logic                        busy,
  output logic                        done,
  regfile_dump_reader_if.master       bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ser_load;
  logic              ser_last;

  regfile_dump_reader_ser #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ser (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (ser_load),
    .addr_i     (cur_q),
    .word_i     (bus.rdata),
    .tx_ready_i (bus.tx_ready),
    .tx_data_o  (bus.tx_data),
    .tx_valid_o (bus.tx_valid),
    .last_o     (ser_last)
  );

  // Address walk: fetch a register, wait for its five bytes, advance or finish.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    raddr_d  = raddr_q;
    ser_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (first_addr <= last_addr) begin
            cur_d   = first_addr;
            last_d  = last_addr;
            raddr_d = first_addr;
            state_d = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FETCH: begin
        // raddr already points at cur, so rdata is the snapshot to capture.
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (ser_last) begin
          if (cur_q == last_q) begin
            state_d = FIN;
          end else begin
            cur_d   = cur_q + 1'b1;
            raddr_d = cur_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status flags are registered copies of the state being entered.
    busy_d = (state_d == FETCH) || (state_d == SEND);
    done_d = (state_d == FIN);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      raddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      raddr_q <= raddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.raddr = raddr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised bench for regfile_dump_reader with a queue-based byte model.
module tb_regfile_dump_reader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              busy;
  logic              done;
  logic [31:0]       regs [32];

  regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  assign bus.rdata = regs[bus.raddr];

  regfile_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         mon_en   = 1'b0;
  int         done_cnt = 0;
  int         rdy_mode = 0;
  bit         tgl      = 1'b0;
  bit         hold_vld = 1'b0;
  logic [7:0] hold_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected stream for a dump: per register, its address then its value LSB first.
  task automatic build_expect(input int f, input int l);
    logic [31:0] w;
    for (int a = f; a <= l; a++) begin
      w = regs[a];
      exp_q.push_back(8'(a));
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  // Stream monitor: transfers against the model, stall stability, done counting.
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (mon_en) begin
      if (hold_vld) begin
        chk("stall_hold", 32'(bus.tx_data), 32'(hold_data));
        chk("stall_valid", 32'(bus.tx_valid), 32'd1);
      end
      hold_vld = 1'b0;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(bus.tx_valid), 32'd0);
        else chk("byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end else if (bus.tx_valid) begin
        hold_vld  = 1'b1;
        hold_data = bus.tx_data;
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  // Sink ready pattern: always, alternating, or random.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.tx_ready = 1'b1;
      1:       begin tgl = ~tgl; bus.tx_ready = tgl; end
      default: bus.tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic run_dump(input int f, input int l, input bit poke);
    int k;
    int base;
    int cyc;
    int budget;
    bit seen;
    bit act_bad;
    k       = (f <= l) ? (l - f + 1) : 0;
    base    = done_cnt;
    budget  = 20 * k + 10;
    seen    = 1'b0;
    act_bad = 1'b0;
    build_expect(f, l);
    @(posedge clk); #1;
    first_addr = ADDR_W'(f);
    last_addr  = ADDR_W'(l);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy !== (k > 0)) act_bad = 1'b1;
      if (k == 0 && bus.tx_valid) act_bad = 1'b1;
      if (poke && cyc == 2) begin
        regs[f] = 32'hFFFF_FFFF;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("bytes_left", 32'(exp_q.size()), 32'd0);
      if (rdy_mode == 0) chk("done_latency", 32'(cyc), 32'(6 * k + 1));
    end else begin
      exp_q.delete();
    end
    chk("busy_valid_during_dump", 32'(act_bad), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic reset_mid_send();
    int base;
    regs[7] = $urandom;
    build_expect(7, 7);
    @(posedge clk); #1;
    first_addr = 5'd7;
    last_addr  = 5'd7;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);   // third byte is on the stream now
    #1;
    rst    = 1'b0;
    mon_en = 1'b0;
    base   = done_cnt;
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_cnt - base), 32'd0);
    mon_en = 1'b1;
    run_dump(7, 7, 1'b0);
  endtask

  initial begin
    bit idle_bad;
    int f;
    int l;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;

    // Reset and quiet idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_raddr", 32'(bus.raddr), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst      = 1'b1;
    mon_en   = 1'b1;
    idle_bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.tx_valid || busy || done) idle_bad = 1'b1;
    end
    chk("idle_quiet", 32'(idle_bad), 32'd0);

    // Single register, free-flowing sink.
    regs[3]  = 32'h1234_5678;
    rdy_mode = 0;
    run_dump(3, 3, 1'b0);
    chk("raddr_hold_idle", 32'(bus.raddr), 32'd3);

    // Two registers with an alternating sink.
    regs[0]  = 32'h0;
    regs[1]  = 32'hA5A5_0F0F;
    rdy_mode = 1;
    run_dump(0, 1, 1'b0);

    // Empty range.
    rdy_mode = 0;
    run_dump(5, 2, 1'b0);

    // Reset in the middle of a register.
    reset_mid_send();

    // Snapshot semantics and start ignored while busy.
    regs[4] = 32'h0BAD_CAFE;
    run_dump(4, 4, 1'b1);

    // Top of the address space and a range starting at zero.
    run_dump(28, 31, 1'b0);
    rdy_mode = 2;
    run_dump(0, 0, 1'b0);

    // Random ranges, values and sink behaviour.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      rdy_mode = $urandom_range(0, 2);
      f = $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) l = (f == 0) ? 0 : $urandom_range(0, f - 1);
      else l = (f + 3 > 31) ? 31 : $urandom_range(f, f + 3);
      run_dump(f, l, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
